universal_shift_register: RTL and testbench

- Parametrised successor to the team's single-bit D storage element.
- WIDTH-bit register clocked on the falling edge, with selectable modes: hold, parallel load, logical shift, rotate, arithmetic shift right and clear.
- Includes a shift counter and a completion pulse.
- Used as the serial/parallel conversion and data-staging element in datapath blocks.

---
 rtl/universal_shift_register_pkg.sv | 22 ++
 rtl/universal_shift_register_if.sv | 32 +++
 rtl/universal_shift_register_shift_counter.sv | 46 ++++
 rtl/universal_shift_register.sv | 87 ++++++++
 tb/tb_universal_shift_register.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/universal_shift_register_pkg.sv
// Shared types and helpers for the universal shift register slice.
// Contents: mode_t operation select, cnt_width() sizing helper.
// Imported by the interface, the counter and the top module.
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        ASR  = 3'd6,
        CLR  = 3'd7
    } mode_t;

    // Bits needed to hold a shift count in the range 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle between a datapath block and the shift register.
// master: drives en, mode, d, sin_l, sin_r; observes q, sout_l, sout_r, cnt, done.
// slave:  the register itself (inputs and outputs mirrored).
interface universal_shift_register_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_width(WIDTH)
);

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    cnt;
    logic             done;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, sout_l, sout_r, cnt, done
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, sout_l, sout_r, cnt, done
    );

endinterface

// File: rtl/universal_shift_register_shift_counter.sv
// Saturating shift counter with a one-cycle completion pulse (falling-edge clocked).
// Latency: cnt and done update one falling edge after inc/clr.
// Backpressure: none; inc while saturated is absorbed, done does not re-pulse.
// Ports: i_clk, i_rst (sync, active-high), i_inc, i_clr, o_cnt, o_done.
module shift_counter
    import usr_pkg::*;
#(
    parameter int MAX = 8,
    parameter int CW  = cnt_width(MAX)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_sat;
    logic          w_last;

    assign w_sat  = (r_cnt == CW'(MAX));
    assign w_last = (r_cnt == CW'(MAX - 1));

    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_inc && !w_sat) begin
            r_cnt  <= r_cnt + 1'b1;
            // Pulse only on the step that reaches MAX; saturated shifts skip this branch.
            r_done <= w_last;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = r_done;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/ASR/clear, falling-edge clocked.
// Latency: every operation is visible one falling edge later; sout_l/sout_r are combinational from q.
// Backpressure: none; en=0 freezes q and cnt and suppresses done.
// Ports: clk, rst (sync, active-high), bus (slave modport: en, mode, d, sin_l, sin_r -> q, sout_l, sout_r, cnt, done).
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    universal_shift_register_if.slave   bus
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_inc;
    logic             w_clr;

    // Shifts are written with shift operators plus an OR-ed fill bit so the
    // same expressions stay legal at WIDTH=1 (rotates and ASR degenerate to hold).
    always_comb begin
        w_q_nxt = r_q;
        w_inc   = 1'b0;
        w_clr   = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                HOLD: w_q_nxt = r_q;
                LOAD: begin
                    w_q_nxt = bus.d;
                    w_clr   = 1'b1;
                end
                SHL: begin
                    w_q_nxt = (r_q << 1) | WIDTH'(bus.sin_r);
                    w_inc   = 1'b1;
                end
                SHR: begin
                    w_q_nxt = (r_q >> 1) | (WIDTH'(bus.sin_l) << (WIDTH - 1));
                    w_inc   = 1'b1;
                end
                ROL: begin
                    w_q_nxt = (r_q << 1) | WIDTH'(r_q[WIDTH-1]);
                    w_inc   = 1'b1;
                end
                ROR: begin
                    w_q_nxt = (r_q >> 1) | (WIDTH'(r_q[0]) << (WIDTH - 1));
                    w_inc   = 1'b1;
                end
                ASR: begin
                    w_q_nxt = (r_q >> 1) | (WIDTH'(r_q[WIDTH-1]) << (WIDTH - 1));
                    w_inc   = 1'b1;
                end
                CLR: begin
                    // Clears to zero, deliberately not to RESET_VAL.
                    w_q_nxt = '0;
                    w_clr   = 1'b1;
                end
                default: w_q_nxt = r_q;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    shift_counter #(
        .MAX (WIDTH)
    ) u_shift_counter (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_inc  (w_inc),
        .i_clr  (w_clr),
        .o_cnt  (bus.cnt),
        .o_done (bus.done)
    );

    assign bus.q      = r_q;
    assign bus.sout_l = r_q[WIDTH-1];
    assign bus.sout_r = r_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: WIDTH=8 (RESET_VAL=A5) and WIDTH=1 instances
// driven in lockstep, compared every cycle against an arithmetic reference model,
// with hand-computed literal expectations at the directed points.
module tb_universal_shift_register;
    import usr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    universal_shift_register_if #(.WIDTH(8)) bus8 ();
    universal_shift_register_if #(.WIDTH(1)) bus1 ();

    universal_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    universal_shift_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int  n_chk  = 0;
    int  n_err  = 0;
    bit  chk_on = 1'b0;

    longint m8_q, m1_q;
    int     m8_cnt, m1_cnt;
    bit     m8_done, m1_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next register value from the mode rules, expressed as plain arithmetic on a w-bit number.
    function automatic longint model_q(input longint q, input int m, input longint dd,
                                       input bit sl, input bit sr, input int w);
        longint full = longint'(1) << w;
        longint msb  = full / 2;
        case (m)
            1:       return dd % full;
            2:       return (q * 2 + sr) % full;
            3:       return q / 2 + (sl ? msb : 0);
            4:       return (q * 2) % full + q / msb;
            5:       return q / 2 + (q % 2) * msb;
            6:       return q / 2 + ((q >= msb) ? msb : 0);
            7:       return 0;
            default: return q;
        endcase
    endfunction

    function automatic int model_cnt(input int c, input bit r, input bit e, input int m, input int w);
        if (r) return 0;
        if (!e) return c;
        if (m == 1 || m == 7) return 0;
        if (m >= 2 && m <= 6) return (c < w) ? c + 1 : w;
        return c;
    endfunction

    task automatic step(input bit r, input bit e, input int m, input logic [7:0] dd,
                        input bit sl, input bit sr);
        bit is_shift;
        @(posedge clk);
        rst        = r;
        bus8.en    = e;    bus1.en    = e;
        bus8.mode  = mode_t'(m);
        bus1.mode  = mode_t'(m);
        bus8.d     = dd;   bus1.d     = dd[0];
        bus8.sin_l = sl;   bus1.sin_l = sl;
        bus8.sin_r = sr;   bus1.sin_r = sr;
        is_shift = !r && e && (m >= 2 && m <= 6);
        m8_done  = is_shift && (m8_cnt == 7);
        m1_done  = is_shift && (m1_cnt == 0);
        m8_q     = r ? 64'hA5 : (e ? model_q(m8_q, m, longint'(dd), sl, sr, 8) : m8_q);
        m1_q     = r ? 64'h0  : (e ? model_q(m1_q, m, longint'(dd[0]), sl, sr, 1) : m1_q);
        m8_cnt   = model_cnt(m8_cnt, r, e, m, 8);
        m1_cnt   = model_cnt(m1_cnt, r, e, m, 1);
        chk_on   = 1'b1;
        @(negedge clk);
        #2;
    endtask

    task automatic lit8(input string name, input logic [7:0] q, input int c, input bit dn);
        check({name, "_q"},    bus8.q,    q);
        check({name, "_cnt"},  bus8.cnt,  c);
        check({name, "_done"}, bus8.done, dn);
    endtask

    // Per-cycle comparison against the model, one time unit after the falling edge.
    always @(negedge clk) begin
        #1;
        if (chk_on) begin
            check("q8",      bus8.q,      m8_q);
            check("sout_l8", bus8.sout_l, m8_q / 128);
            check("sout_r8", bus8.sout_r, m8_q % 2);
            check("cnt8",    bus8.cnt,    m8_cnt);
            check("done8",   bus8.done,   m8_done);
            check("q1",      bus1.q,      m1_q);
            check("sout_l1", bus1.sout_l, m1_q);
            check("sout_r1", bus1.sout_r, m1_q);
            check("cnt1",    bus1.cnt,    m1_cnt);
            check("done1",   bus1.done,   m1_done);
        end
    end

    always @(negedge clk) begin
        if (bus8.en === 1'b1)
            assert (!$isunknown(bus8.mode)) else $error("mode unknown while enabled");
    end

    initial begin
        int          pulses;
        logic [7:0]  bits;
        bit          r, e, sl, sr;
        int          m;
        logic [7:0]  dd;

        bus8.en = 1'b0; bus8.mode = HOLD; bus8.d = '0; bus8.sin_l = 1'b0; bus8.sin_r = 1'b0;
        bus1.en = 1'b0; bus1.mode = HOLD; bus1.d = '0; bus1.sin_l = 1'b0; bus1.sin_r = 1'b0;
        m8_q = 0; m1_q = 0; m8_cnt = 0; m1_cnt = 0; m8_done = 0; m1_done = 0;

        // Reset wins over an enabled LOAD, then idle cycles hold.
        step(1, 1, 1, 8'hFF, 0, 0);
        lit8("reset", 8'hA5, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h3C, 1, 1);
        lit8("idle", 8'hA5, 0, 0);

        // Serial-in through SHL.
        step(0, 1, 1, 8'h00, 0, 0);
        bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2, 8'h00, 0, bits[7-i]);
            if (i == 6) lit8("shl7", 8'h59, 7, 0);
        end
        lit8("shl8", 8'hB2, 8, 1);
        step(0, 1, 2, 8'h00, 0, 0);
        lit8("shl9", 8'h64, 8, 0);

        // Rotates, ASR and SHR.
        step(0, 1, 1, 8'h81, 0, 0);
        check("sout_l_81", bus8.sout_l, 1'b1);
        check("sout_r_81", bus8.sout_r, 1'b1);
        step(0, 1, 4, 8'h00, 0, 0); lit8("rol", 8'h03, 1, 0);
        step(0, 1, 5, 8'h00, 0, 0); lit8("ror1", 8'h81, 2, 0);
        step(0, 1, 5, 8'h00, 0, 0); lit8("ror2", 8'hC0, 3, 0);
        step(0, 1, 1, 8'h90, 0, 0);
        step(0, 1, 6, 8'h00, 0, 0);
        step(0, 1, 6, 8'h00, 0, 0); lit8("asr2", 8'hE4, 2, 0);
        step(0, 1, 3, 8'h00, 0, 1); lit8("shr", 8'h72, 3, 0);
        check("sout_r_72", bus8.sout_r, 1'b0);

        // Clear, then reset priority over an enabled shift.
        step(0, 1, 1, 8'h5A, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 2, 8'h00, 0, 0);
        check("cnt3", bus8.cnt, 3);
        step(0, 1, 7, 8'hFF, 0, 0); lit8("clr", 8'h00, 0, 0);
        step(1, 1, 2, 8'h00, 1, 1); lit8("rst_pri", 8'hA5, 0, 0);

        // Reset mid-sequence suppresses done; a fresh run pulses exactly once.
        for (int i = 0; i < 7; i++) step(0, 1, 2, 8'h00, 0, 1);
        check("cnt7", bus8.cnt, 7);
        step(1, 1, 2, 8'h00, 0, 1); lit8("rst_mid", 8'hA5, 0, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 2, 8'h00, 0, 0);
            pulses += int'(bus8.done);
        end
        check("done_pulses", pulses, 1);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = $urandom_range(0, 7);
            dd = 8'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
            step(r, e, m, dd, sl, sr);
        end

        // WIDTH=1 boundary.
        step(1, 0, 0, 8'h00, 0, 0);
        check("w1_rst_q", bus1.q, 1'b0);
        step(0, 1, 2, 8'h00, 0, 1);
        check("w1_shl_q", bus1.q, 1'b1);
        check("w1_shl_cnt", bus1.cnt, 1'b1);
        check("w1_shl_done", bus1.done, 1'b1);
        step(0, 1, 4, 8'h00, 0, 0);
        check("w1_rol_q", bus1.q, 1'b1);
        check("w1_rol_cnt", bus1.cnt, 1'b1);
        check("w1_rol_done", bus1.done, 1'b0);
        step(0, 1, 3, 8'h00, 0, 0);
        check("w1_shr_q", bus1.q, 1'b0);

        chk_on = 1'b0;
        #20;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
